// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for inv_sub_bytes_seq: input state and result, each on its own valid/ready pair.
// The slave modport is the engine side; the master modport is the producer/consumer side.
interface inv_sub_bytes_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] x;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] y;
   logic         busy;

   modport master (
      output in_valid, x, out_ready,
      input  in_ready, out_valid, y, busy
   );

   modport slave (
      input  in_valid, x, out_ready,
      output in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Byte-serial AES InvSubBytes: inverse affine, then x^254 by square-and-multiply; 128-cycle latency, 32 with INV_SUB_BYTES_PAR4_EN.
// The result holds in DONE until out_ready; in_ready stays low from the accept edge until the return to IDLE.
module inv_sub_bytes_seq #(
   parameter logic [8:0] POLY = 9'h11B
) (
   input  logic               clk,
   input  logic               rst_n,
   inv_sub_bytes_seq_if.slave bus
);

`ifdef INV_SUB_BYTES_PAR4_EN
   localparam int LANES = 4;
`else
   localparam int LANES = 1;
`endif
   localparam int         NPASS = 16 / LANES;
   localparam logic [7:0] EXP   = 8'hFE;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;
   logic [3:0]       r_idx;
   logic [2:0]       r_step;
   logic [15:0][7:0] r_x;
   logic [15:0][7:0] r_y;
   logic [7:0]       r_acc  [LANES];
   logic [7:0]       r_base [LANES];
   logic [7:0]       w_acc_nxt [LANES];
   logic [15:0][7:0] w_x;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ s;
         s = s[7] ? ({s[6:0], 1'b0} ^ POLY[7:0]) : {s[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] invaff(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   // Byte 0 sits in the top byte of the bus, so byte n lives at packed index 15-n.
   function automatic logic [3:0] byte_pos(input logic [3:0] pass, input int lane);
      return 4'd15 - 4'(int'(pass) * LANES + lane);
   endfunction

   assign w_x = bus.x;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         w_acc_nxt[k] = gmul(gmul(r_acc[k], r_acc[k]), EXP[3'd7 - r_step] ? r_base[k] : 8'h01);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_idx       <= '0;
         r_step      <= '0;
         r_x         <= '0;
         r_y         <= '0;
         for (int k = 0; k < LANES; k++) begin
            r_acc[k]  <= '0;
            r_base[k] <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (r_in_ready && bus.in_valid) begin
                  r_x        <= w_x;
                  r_idx      <= '0;
                  r_step     <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= CALC;
                  for (int k = 0; k < LANES; k++) begin
                     r_acc[k]  <= 8'h01;
                     r_base[k] <= invaff(w_x[byte_pos(4'd0, k)]);
                  end
               end
            end
            CALC: begin
               if (r_step == 3'd7) begin
                  for (int k = 0; k < LANES; k++) begin
                     r_y[byte_pos(r_idx, k)] <= w_acc_nxt[k];
                  end
                  if (r_idx == 4'(NPASS - 1)) begin
                     for (int k = 0; k < LANES; k++) r_acc[k] <= w_acc_nxt[k];
                     r_busy      <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     // Next byte is loaded on the same edge, so there is no bubble between bytes.
                     r_idx  <= r_idx + 4'd1;
                     r_step <= '0;
                     for (int k = 0; k < LANES; k++) begin
                        r_acc[k]  <= 8'h01;
                        r_base[k] <= invaff(r_x[byte_pos(r_idx + 4'd1, k)]);
                     end
                  end
               end else begin
                  r_step <= r_step + 3'd1;
                  for (int k = 0; k < LANES; k++) r_acc[k] <= w_acc_nxt[k];
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.y         = r_y;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: random and directed states checked against a log/antilog InvSbox model.
module tb_inv_sub_bytes_seq;
`ifdef INV_SUB_BYTES_PAR4_EN
   localparam int LAT = 32;
`else
   localparam int LAT = 128;
`endif
   localparam int MID = (LAT > 60) ? 50 : 20;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   int         cyc   = 0;
   int         errors = 0;
   int         checks = 0;
   logic [7:0] sbox  [256];
   logic [7:0] isbox [256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   inv_sub_bytes_seq_if bus();
   inv_sub_bytes_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return 8'((v << n) | (v >> (8 - n)));
   endfunction

   // Forward S-box from the AES definition (inverse via powers of generator 3), then inverted.
   task automatic build_model();
      logic [7:0] e  [256];
      int         lg [256];
      logic [7:0] v;
      logic [7:0] inv;
      v = 8'h01;
      for (int i = 0; i < 255; i++) begin
         e[i]  = v;
         lg[v] = i;
         v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00) ^ v;
      end
      for (int b = 0; b < 256; b++) begin
         inv = (b == 0) ? 8'h00 : e[(255 - lg[b]) % 255];
         sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         isbox[sbox[b]] = 8'(b);
      end
   endtask

   function automatic logic [127:0] ref_state(input logic [127:0] xv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = isbox[xv[127-8*i -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic send(input logic [127:0] xv);
      int n;
      n = 0;
      while (!bus.in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      bus.x        = xv;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.x        = rnd128();
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x         = '0;
      repeat (3) @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.y !== 128'h0) begin errors++; $display("FAIL reset_y: got %h want 0", bus.y); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int lat;
      bus.out_ready = 1'b1;
      send(128'h637c777bf26b6fc53001672bfed7ab76);
      checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL single_busy: busy=%b in_ready=%b want busy=1 in_ready=0", bus.busy, bus.in_ready);
      end
      wait_out(lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
      checks++; if (bus.y !== 128'h000102030405060708090a0b0c0d0e0f) begin
         errors++; $display("FAIL single_y: got %h want 000102030405060708090a0b0c0d0e0f", bus.y);
      end
      @(negedge clk);
   endtask

   task automatic test_spot();
      logic [7:0] si [4];
      logic [7:0] so [4];
      int lat;
      si = '{8'h16, 8'hed, 8'h52, 8'h63};
      so = '{8'hff, 8'h53, 8'h48, 8'h00};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send({16{si[i]}});
         wait_out(lat);
         checks++; if (lat != LAT) begin errors++; $display("FAIL spot_latency %h: got %0d want %0d", si[i], lat, LAT); end
         checks++; if (bus.y !== {16{so[i]}}) begin errors++; $display("FAIL spot_y %h: got %h want %h", si[i], bus.y, {16{so[i]}}); end
         @(negedge clk);
      end
   endtask

   task automatic test_exhaustive();
      int perm [256];
      int j;
      int t;
      int b;
      int lat;
      logic [127:0] xv;
      logic [7:0]   got;
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      bus.out_ready = 1'b1;
      for (int s = 0; s < 16; s++) begin
         for (int i = 0; i < 16; i++) xv[127-8*i -: 8] = 8'(perm[16*s+i]);
         send(xv);
         wait_out(lat);
         checks++; if (lat != LAT) begin errors++; $display("FAIL exh_latency state %0d: got %0d want %0d", s, lat, LAT); end
         for (int i = 0; i < 16; i++) begin
            b   = perm[16*s+i];
            got = bus.y[127-8*i -: 8];
            checks++; if (got !== isbox[b]) begin errors++; $display("FAIL exh_inv %h: got %h want %h", b, got, isbox[b]); end
            checks++; if (sbox[got] !== 8'(b)) begin errors++; $display("FAIL exh_roundtrip %h: fwd(got)=%h want %h", b, sbox[got], b); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] xa;
      logic [127:0] xb;
      logic [127:0] y0;
      int lat;
      xa = rnd128();
      xb = rnd128();
      bus.out_ready = 1'b0;
      send(xa);
      wait_out(lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
      y0 = bus.y;
      checks++; if (y0 !== ref_state(xa)) begin errors++; $display("FAIL bp_y: got %h want %h", y0, ref_state(xa)); end
      for (int c = 0; c < 20; c++) begin
         if (c == 5) begin
            bus.in_valid = 1'b1;
            bus.x        = rnd128();
         end
         checks++; if (bus.out_valid !== 1'b1 || bus.y !== y0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b y=%h want 1 0 %h", c, bus.out_valid, bus.in_ready, bus.y, y0);
         end
         @(negedge clk);
      end
      bus.x         = xb;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_accept_after_idle: busy=%b want 1", bus.busy); end
      wait_out(lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL bp_next_latency: got %0d want %0d", lat, LAT); end
      checks++; if (bus.y !== ref_state(xb)) begin errors++; $display("FAIL bp_next_y: got %h want %h", bus.y, ref_state(xb)); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [127:0] xb;
      int lat;
      int seen;
      xb = rnd128();
      bus.out_ready = 1'b1;
      send(rnd128());
      repeat (MID - 1) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
      checks++; if (bus.y !== 128'h0) begin errors++; $display("FAIL mid_y: got %h want 0", bus.y); end
      seen = 0;
      for (int c = 0; c < LAT + 10; c++) begin
         if (bus.out_valid) seen++;
         @(negedge clk);
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_result: out_valid seen %0d cycles want 0", seen); end
      send(xb);
      wait_out(lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL mid_next_latency: got %0d want %0d", lat, LAT); end
      checks++; if (bus.y !== ref_state(xb)) begin errors++; $display("FAIL mid_next_y: got %h want %h", bus.y, ref_state(xb)); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [127:0] xs [5];
      int           acc_at [5];
      logic [127:0] got [$];
      int n;
      int lat;
      for (int k = 0; k < 5; k++) xs[k] = rnd128();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.x = xs[k];
         n = 0;
         while (!bus.in_ready && n < 400) begin
            if (bus.out_valid) got.push_back(bus.y);
            @(negedge clk);
            n++;
         end
         checks++; if (n >= 400) begin errors++; $display("FAIL b2b_wait_ready %0d: waited %0d cycles want < 400", k, n); end
         @(negedge clk);
         acc_at[k] = cyc;
      end
      bus.in_valid = 1'b0;
      wait_out(lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_last_latency: got %0d want %0d", lat, LAT); end
      got.push_back(bus.y);
      @(negedge clk);
      for (int k = 1; k < 5; k++) begin
         checks++; if (acc_at[k] - acc_at[k-1] != LAT + 2) begin
            errors++; $display("FAIL b2b_spacing %0d: got %0d want %0d", k, acc_at[k] - acc_at[k-1], LAT + 2);
         end
      end
      checks++; if (got.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", got.size()); end
      for (int k = 0; k < 5; k++) begin
         if (k < got.size()) begin
            checks++; if (got[k] !== ref_state(xs[k])) begin
               errors++; $display("FAIL b2b_y %0d: got %h want %h", k, got[k], ref_state(xs[k]));
            end
         end
      end
   endtask

   initial begin
      build_model();
      test_reset();
      test_single();
      test_spot();
      test_exhaustive();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Byte-serial inverse SubBytes engine for the AES decryption datapath.
- Computes InvSbox(b) = GF(2^8) inverse of the inverse-affine transform of b, in arithmetic form with no 256-entry table.
- Inversion uses iterative square-and-multiply, x^254, one exponent bit per cycle.
- Accepts a 128-bit state over a valid/ready handshake and returns the substituted state over a second valid/ready handshake.

Parameters:
- POLY, 9'h11B, GF(2^8) reduction polynomial. Only the AES value is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input state valid
- in_ready  out  1  engine can accept a state
- x  in  128  input state; byte 0 = x[127:120] … byte 15 = x[7:0]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- y  out  128  result state, same byte order as x
- busy  out  1  high while computing (CALC state)

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; in_ready=1 on the next cycle; out_valid=0; busy=0; y=0.
  - Internal byte index, step counter and accumulator are cleared.
  - Reset mid-CALC or mid-DONE aborts the operation; no partial result is output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch x; idx=0; step=0; acc=8'h01; base=invaff(byte0); go to CALC.
- invaff(b) = rotl(b,1) ^ rotl(b,3) ^ rotl(b,6) ^ 8'h05.
- CALC:
  - in_ready=0, busy=1.
  - Each cycle: acc <= gmul(gsq(acc), e[7-step] ? base : 8'h01), with e = 8'b11111110 (254).
  - gmul is a bitwise-reduced multiply mod POLY. Both GF operations are combinational within the cycle.
  - When step==7:
    - Write the new acc value into result byte idx.
    - If idx==15, go to DONE.
    - Otherwise idx++, step=0, acc=8'h01, base=invaff(next byte), all in the same edge. No bubble between bytes.
  - Otherwise step++.
- Zero input: 0^254 evaluates to 0, so InvSbox(0x63)=0x00 with no special case.
- DONE:
  - out_valid=1; y holds the full result; in_ready=0.
  - On out_ready=1, go to IDLE. out_valid drops on the following cycle.
- Latency: exactly 128 cycles from the accept edge to the edge that raises out_valid. Throughput is one state per 129+ cycles (plus DONE dwell).
- Simultaneous events:
  - in_valid during CALC/DONE is ignored; in_ready=0 and no latch.
  - out_ready asserted before DONE has no effect.
  - In DONE, y and out_valid stay stable until accepted.
- Handshake stability:
  - x is sampled only at the accept edge; it may change afterwards.
  - y changes only when written in CALC or cleared by reset. y is undefined-to-consumer unless out_valid=1, but is driven deterministically.

Optional Feature:
- Macro: INV_SUB_BYTES_PAR4_EN.
- Defined:
  - Four byte lanes run in parallel.
  - Lane k processes byte 4*j+k in pass j (j=0..3); each pass is 8 cycles.
  - Latency becomes 32 cycles; idx counts passes 0..3.
  - All other handshake, reset and DONE rules are unchanged.
- Undefined: single lane, latency 128 as above.

Test Plan:
1. Reset then single state:
   - Drive x=128'h637c777bf26b6fc53001672bfed7ab76, in_valid=1 for one cycle, out_ready=1.
   - Expect y=128'h000102030405060708090a0b0c0d0e0f and out_valid high exactly 128 cycles after accept (32 with PAR4).
2. Per-byte spot values:
   - x with all bytes 0x16 → all bytes 0xff.
   - All 0xed → all 0x53.
   - All 0x52 → all 0x48.
   - All 0x63 → all 0x00.
3. Exhaustive:
   - Stream all 256 byte values (16 per state, 16 states) with out_ready=1.
   - Each output byte equals the golden InvSbox.
   - fwd_sbox(InvSbox(b))==b for every b.
4. Backpressure:
   - Hold out_ready=0 for 20 cycles after out_valid.
   - y and out_valid are stable; in_ready=0.
   - A new in_valid in this window is not accepted.
   - Release out_ready; the next state is accepted only after return to IDLE.
5. Reset mid-operation:
   - Assert rst_n=0 at cycle 50 of CALC for one edge.
   - Next cycle: out_valid=0, busy=0, in_ready=1, y=0.
   - A following state completes with correct result and latency.
6. Back-to-back:
   - in_valid held high with new x each accept, out_ready=1.
   - Consecutive accepts are 130 cycles apart (128 CALC + DONE + IDLE).
   - Results are in order and correct.
